// File: rtl/security_pkg.sv
// Shared types for the device-identity front-end and its consumer key_vault.
package security_pkg;

    localparam int DNA_WIDTH_DEFAULT = 57;

    // Reader sequence states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } dna_rd_state_e;

    // Which of the two redundant reads is in flight.
    typedef enum logic {
        PASS_FIRST  = 1'b0,
        PASS_SECOND = 1'b1
    } dna_pass_e;

endpackage

// File: rtl/dna_port_reader_clk_div.sv
// Divider that produces the DNA_PORT clock from clk, plus strobes that mark
// the last clk cycle before each dna_clk rising and falling edge.
module dna_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic dna_clk,
    output logic rise_next,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_r;
    logic             dna_clk_r;
    logic             last_s;

    assign last_s    = (cnt_r == DIV_W'(CLK_DIV - 1));
    assign rise_next = enable && last_s && !dna_clk_r;
    assign fall      = enable && last_s && dna_clk_r;
    assign dna_clk   = dna_clk_r;

    // Half-period counter; the clock is parked low whenever the divider is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {DIV_W{1'b0}};
            dna_clk_r <= 1'b0;
        end else if (!enable) begin
            cnt_r     <= {DIV_W{1'b0}};
            dna_clk_r <= 1'b0;
        end else if (last_s) begin
            cnt_r     <= {DIV_W{1'b0}};
            dna_clk_r <= ~dna_clk_r;
        end else begin
            cnt_r     <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/dna_port_reader.sv
// Reads the device DNA twice over the DNA_PORT serial pins, qualifies the pair
// and presents a stable parallel value; retries bad pairs, then locks in error.
module dna_port_reader
    import security_pkg::*;
#(
    parameter int  DNA_WIDTH = DNA_WIDTH_DEFAULT,
    parameter int  CLK_DIV   = 4,
    parameter int  MAX_RETRY = 3,
    localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 dna_clk,
    output logic                 dna_read,
    output logic                 dna_shift,
    output logic                 dna_din,
    input  logic                 dna_dout,
    output logic [DNA_WIDTH-1:0] dna_value,
    output logic                 dna_valid,
    output logic                 busy,
    output logic                 dna_error,
    output logic [RETRY_W-1:0]   retry_count
);

    localparam int CNT_W = $clog2(DNA_WIDTH + 1);

    dna_rd_state_e        state_r;
    dna_rd_state_e        state_next_s;
    dna_pass_e            pass_r;
    logic                 auto_r;
    logic                 launch_r;
    logic                 busy_r;
    logic                 valid_r;
    logic                 error_r;
    logic                 read_r;
    logic                 shift_r;
    logic [RETRY_W-1:0]   retry_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [DNA_WIDTH-1:0] work_r;
    logic [DNA_WIDTH-1:0] cap_r;
    logic [DNA_WIDTH-1:0] value_r;

    logic                 div_en_s;
    logic                 rise_next_s;
    logic                 fall_s;
    logic                 accept_s;
    logic                 last_bit_s;
    logic                 retry_left_s;
    logic                 pair_ok_s;

    // A pair is trusted only if both reads agree and the value is not a stuck line.
    function automatic logic pair_ok(input logic [DNA_WIDTH-1:0] a,
                                     input logic [DNA_WIDTH-1:0] b);
        return (a == b) && (a != {DNA_WIDTH{1'b0}}) && (a != {DNA_WIDTH{1'b1}});
    endfunction

    assign div_en_s     = (state_r == LOAD) || (state_r == SHIFT);
    assign last_bit_s   = (bit_cnt_r == CNT_W'(DNA_WIDTH));
    assign retry_left_s = (retry_r < RETRY_W'(MAX_RETRY));
    assign pair_ok_s    = pair_ok(cap_r, work_r);

    dna_clk_div #(
        .CLK_DIV   (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .enable    (div_en_s),
        .dna_clk   (dna_clk),
        .rise_next (rise_next_s),
        .fall      (fall_s)
    );

    // Request acceptance: the post-reset auto-start or a start pulse while not busy.
    always_comb begin
        accept_s = 1'b0;
        if (!busy_r && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR))) begin
            accept_s = auto_r || start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; LOAD/SHIFT advance only on dna_clk falling edges so the
    // pin levels settle half a period before the following rising edge.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (launch_r) state_next_s = LOAD;
                else          state_next_s = state_r;
            end
            LOAD: begin
                if (fall_s) state_next_s = SHIFT;
                else        state_next_s = state_r;
            end
            SHIFT: begin
                if (fall_s && last_bit_s) begin
                    if (pass_r == PASS_FIRST) state_next_s = LOAD;
                    else                      state_next_s = COMPARE;
                end else begin
                    state_next_s = state_r;
                end
            end
            COMPARE: begin
                if (pair_ok_s)         state_next_s = DONE;
                else if (retry_left_s) state_next_s = LOAD;
                else                   state_next_s = ERROR;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath, status flags and registered pin drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_r    <= PASS_FIRST;
            auto_r    <= 1'b1;
            launch_r  <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            read_r    <= 1'b0;
            shift_r   <= 1'b0;
            retry_r   <= {RETRY_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            work_r    <= {DNA_WIDTH{1'b0}};
            cap_r     <= {DNA_WIDTH{1'b0}};
            value_r   <= {DNA_WIDTH{1'b0}};
        end else begin
            launch_r <= accept_s;
            read_r   <= (state_next_s == LOAD);
            shift_r  <= (state_next_s == SHIFT);

            if (accept_s) begin
                auto_r  <= 1'b0;
                busy_r  <= 1'b1;
                valid_r <= 1'b0;
                error_r <= 1'b0;
                retry_r <= {RETRY_W{1'b0}};
                value_r <= {DNA_WIDTH{1'b0}};
            end

            case (state_r)
                LOAD: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
                SHIFT: begin
                    if (rise_next_s) begin
                        work_r    <= {work_r[DNA_WIDTH-2:0], dna_dout};
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                    end
                    if (fall_s && last_bit_s && (pass_r == PASS_FIRST)) begin
                        cap_r  <= work_r;
                        pass_r <= PASS_SECOND;
                    end
                end
                COMPARE: begin
                    pass_r <= PASS_FIRST;
                    if (pair_ok_s) begin
                        value_r <= work_r;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (retry_left_s) begin
                        retry_r <= retry_r + 1'b1;
                    end else begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    pass_r <= PASS_FIRST;
                end
            endcase
        end
    end

    assign dna_read    = read_r;
    assign dna_shift   = shift_r;
    assign dna_din     = 1'b0;
    assign dna_value   = value_r;
    assign dna_valid   = valid_r;
    assign busy        = busy_r;
    assign dna_error   = error_r;
    assign retry_count = retry_r;

endmodule

// File: tb/tb_dna_port_reader.sv
// Bench for dna_port_reader: a behavioural DNA_PORT stub serves per-pass values,
// and a pair-level model predicts the result, retries and completion cycle.
module tb_dna_port_reader;

    localparam int W  = 57;
    localparam int CD = 4;
    localparam int MR = 3;
    localparam int P  = (1 + W) * 2 * CD;
    localparam int T_CLEAN = 2 * P + 2;
    localparam int T_RETRY = 2 * P + 1;
    localparam int BUDGET  = 6000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dna_clk, dna_read, dna_shift, dna_din, dna_dout;
    logic [W-1:0] dna_value;
    logic         dna_valid, busy, dna_error;
    logic [1:0]   retry_count;

    int checks = 0;
    int errors = 0;

    dna_port_reader #(.DNA_WIDTH(W), .CLK_DIV(CD), .MAX_RETRY(MR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dna_clk     (dna_clk),
        .dna_read    (dna_read),
        .dna_shift   (dna_shift),
        .dna_din     (dna_din),
        .dna_dout    (dna_dout),
        .dna_value   (dna_value),
        .dna_valid   (dna_valid),
        .busy        (busy),
        .dna_error   (dna_error),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    // DNA_PORT stub: READ loads the value for the current pass, SHIFT moves it out MSB first.
    logic [W-1:0] pass_vals[$];
    int           base_load = 0;
    int           loads_total = 0;
    int           shifts_total = 0;
    int           bad_edges = 0;
    logic [W-1:0] sr = '0;
    assign dna_dout = sr[W-1];

    always @(posedge dna_clk) begin : stub_p
        int idx;
        if (dna_read && !dna_shift) begin
            idx = loads_total - base_load;
            sr <= (idx >= 0 && idx < pass_vals.size()) ? pass_vals[idx] : '0;
            loads_total <= loads_total + 1;
        end else if (dna_shift && !dna_read) begin
            sr <= {sr[W-2:0], dna_din};
            shifts_total <= shifts_total + 1;
        end else begin
            bad_edges <= bad_edges + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_dna();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Pair-level model: walk the pairs, first good one wins, else error after MR retries.
    task automatic model(output logic ev, output logic ee, output logic [W-1:0] evalue,
                         output int eretry, output int elat, output int epasses);
        logic [W-1:0] a, b;
        logic [W-1:0] ones;
        bit found;
        ones = '1;
        found = 0;
        ev = 1'b0; ee = 1'b0; evalue = '0;
        eretry = MR; elat = T_CLEAN + MR * T_RETRY; epasses = 2 * (MR + 1);
        for (int k = 0; k <= MR; k++) begin
            if (!found) begin
                a = (2 * k < pass_vals.size()) ? pass_vals[2 * k] : '0;
                b = (2 * k + 1 < pass_vals.size()) ? pass_vals[2 * k + 1] : '0;
                if (a == b && a != '0 && a != ones) begin
                    found = 1;
                    ev = 1'b1; evalue = a; eretry = k;
                    elat = T_CLEAN + k * T_RETRY;
                    epasses = 2 * (k + 1);
                end
            end
        end
        if (!found) ee = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_dna_clk"},   dna_clk,     0);
        check({name, "_dna_read"},  dna_read,    0);
        check({name, "_dna_shift"}, dna_shift,   0);
        check({name, "_dna_din"},   dna_din,     0);
        check({name, "_valid"},     dna_valid,   0);
        check({name, "_busy"},      busy,        0);
        check({name, "_error"},     dna_error,   0);
        check({name, "_value"},     dna_value,   0);
        check({name, "_retry"},     retry_count, 0);
    endtask

    // One sequence: launched by start (or by the reset release the caller just did).
    task automatic run_seq(input string name, input bit use_start, input int inject_at);
        logic         ev, ee;
        logic [W-1:0] evalue;
        int           eretry, elat, epasses;
        int           n, l0, s0, b0;
        bit           done;
        model(ev, ee, evalue, eretry, elat, epasses);
        base_load = loads_total;
        l0 = loads_total; s0 = shifts_total; b0 = bad_edges;
        if (use_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        check({name, "_busy_rise"},   busy,      1);
        check({name, "_valid_clear"}, dna_valid, 0);
        check({name, "_value_clear"}, dna_value, 0);
        done = 0;
        while (!done && n < BUDGET) begin
            @(posedge clk);
            n++;
            #1;
            if (dna_valid || dna_error) done = 1;
            else if (n == inject_at)    start = 1'b1;
            else                        start = 1'b0;
        end
        start = 1'b0;
        check({name, "_latency"}, n,           elat);
        check({name, "_valid"},   dna_valid,   ev);
        check({name, "_error"},   dna_error,   ee);
        check({name, "_value"},   dna_value,   evalue);
        check({name, "_retry"},   retry_count, eretry);
        check({name, "_busy"},    busy,        0);
        check({name, "_reads"},   loads_total - l0,  epasses);
        check({name, "_shifts"},  shifts_total - s0, epasses * W);
        check({name, "_pin_bad"}, bad_edges - b0,    0);
    endtask

    initial begin
        logic [W-1:0] v, b;
        int bit_i;

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Clean read from auto-start after reset.
        pass_vals.delete();
        v = 57'h1A2B3C4D5E6F701;
        pass_vals.push_back(v);
        pass_vals.push_back(v);
        @(negedge clk);
        rst = 1'b0;
        run_seq("clean", 1'b0, -1);

        // Start in DONE re-reads a fresh random value.
        pass_vals.delete();
        v = rand_dna();
        pass_vals.push_back(v);
        pass_vals.push_back(v);
        run_seq("reread", 1'b1, -1);

        // Transient: pass 2 of pair 1 has bit 0 flipped.
        pass_vals.delete();
        v = rand_dna();
        b = v;
        b[0] = ~b[0];
        pass_vals.push_back(v);
        pass_vals.push_back(b);
        pass_vals.push_back(v);
        pass_vals.push_back(v);
        run_seq("transient", 1'b1, -1);

        // Start mid-SHIFT is ignored.
        pass_vals.delete();
        v = rand_dna();
        pass_vals.push_back(v);
        pass_vals.push_back(v);
        run_seq("start_busy", 1'b1, 300);

        // Stuck DOUT low, then high.
        pass_vals.delete();
        for (int i = 0; i < 8; i++) pass_vals.push_back('0);
        run_seq("stuck0", 1'b1, -1);
        pass_vals.delete();
        for (int i = 0; i < 8; i++) pass_vals.push_back('1);
        run_seq("stuck1", 1'b1, -1);

        // Start in ERROR recovers; reset at cycle 300 aborts, auto-start repeats.
        pass_vals.delete();
        v = rand_dna();
        pass_vals.push_back(v);
        pass_vals.push_back(v);
        base_load = loads_total;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_error_cleared", dna_error, 0);
        repeat (299) @(posedge clk);
        #1;
        check("abort_in_shift", dna_shift, 1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        run_seq("after_abort", 1'b0, -1);

        // Randomised pairs with random single-bit disagreements.
        for (int r = 0; r < 4; r++) begin
            pass_vals.delete();
            v = rand_dna();
            for (int k = 0; k < 4; k++) begin
                b = v;
                if ($urandom_range(1, 0) == 1) begin
                    bit_i = $urandom_range(W - 1, 0);
                    b[bit_i] = ~b[bit_i];
                end
                if ($urandom_range(1, 0) == 1) begin
                    pass_vals.push_back(v);
                    pass_vals.push_back(b);
                end else begin
                    pass_vals.push_back(b);
                    pass_vals.push_back(v);
                end
            end
            run_seq($sformatf("rand%0d", r), 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dna_port_reader.md
# dna_port_reader

Serial front-end for the FPGA Device DNA primitive. It drives the DNA_PORT READ/SHIFT/CLK pins and deserialises the 57-bit DNA, reading it twice and requiring both passes to agree. It then presents a stable, qualified parallel value to `key_vault`, which consumes `dna_value` in place of a raw primitive output. The block retries inconsistent or stuck reads and raises a sticky error that the vault treats as a lock condition.

## Interface
Parameters:
- `DNA_WIDTH`, 57: DNA bits per read.
- `CLK_DIV`, 4: `dna_clk` half-period in `clk` cycles; must be ≥1.
- `MAX_RETRY`, 3: extra read pairs attempted after a failed pair; must be ≥0.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request to (re)read the DNA.
- `dna_clk`  out  1: drives DNA_PORT.CLK.
- `dna_read`  out  1: drives DNA_PORT.READ.
- `dna_shift`  out  1: drives DNA_PORT.SHIFT.
- `dna_din`  out  1: drives DNA_PORT.DIN; constant 0.
- `dna_dout`  in  1: from DNA_PORT.DOUT.
- `dna_value`  out  DNA_WIDTH: qualified DNA, MSB = first bit shifted out.
- `dna_valid`  out  1: `dna_value` is qualified; level signal.
- `busy`  out  1: a read sequence is in progress.
- `dna_error`  out  1: sticky; retries exhausted.
- `retry_count`  out  $clog2(MAX_RETRY+1): failed pairs in the current sequence.

## Operation
States:
- **IDLE**
  - Entered at reset; the sequence auto-starts on the first cycle after `rst` deasserts.
  - A `start` pulse also launches a sequence.
- **LOAD**
  - `dna_read` is 1 and `dna_shift` is 0 for exactly one `dna_clk` period, giving one rising edge.
- **SHIFT**
  - `dna_read` is 0 and `dna_shift` is 1.
  - There are DNA_WIDTH `dna_clk` periods.
  - `dna_dout` is sampled on the `clk` cycle immediately before each `dna_clk` rising edge.
  - Each sample is shifted into the LSB of the working register, so the first sample ends up at the MSB.
- **Second pass**
  - After pass 1, the working register is copied to a capture register.
  - LOAD→SHIFT repeats as pass 2.
- **COMPARE** (one cycle). The pair passes only when all of the following hold:
  - pass1 == pass2;
  - the value is not all-zeros;
  - the value is not all-ones.
- **On pass**:
  - `dna_value` ← the value;
  - `dna_valid` ← 1;
  - go to DONE.
- **On fail**:
  - if `retry_count` < MAX_RETRY: increment `retry_count` and go to LOAD (new pair);
  - otherwise: set `dna_error` to 1, keep `dna_valid` at 0, and go to ERROR.
- **DONE / ERROR**
  - Outputs are held.
  - `start` is accepted. On acceptance, `dna_valid`, `dna_error` and `retry_count` clear to 0 and the block goes to LOAD.
- **`start` while busy**: ignored.
- **`dna_clk` generation**: `clk`-domain divider.
  - Toggles every CLK_DIV cycles while busy.
  - Held low in IDLE, DONE and ERROR.
- **`dna_value` update rule**: changes only at COMPARE success. It is otherwise zero after reset and otherwise holds its last value, except that it is cleared on `start` acceptance.

## Timing
- Reset values:
  - `dna_clk`, `dna_read`, `dna_shift`, `dna_din`, `dna_valid`, `busy`, `dna_error` are all 0;
  - `dna_value` and `retry_count` are 0.
- Asserting `rst` mid-sequence aborts immediately: all outputs return to reset values and the auto-start repeats after release.
- `busy` rises on the cycle after `start` acceptance (or the first post-reset cycle). `busy` falls on the cycle after COMPARE success or final failure.
- One pass P = (1+DNA_WIDTH)·2·CLK_DIV `clk` cycles. With defaults, P = 464.
- Latency for a clean read, measured from the cycle `start` is sampled high to the cycle `dna_valid` is first seen high, is 2·P + 2 cycles. With defaults, that is 930.
- Each failed pair adds 2·P + 1 cycles.
- `dna_read` and `dna_shift` change only on `clk` edges where `dna_clk` falls or is low, which gives half a period of setup before every rising edge.
- `dna_valid`, `dna_error` and `busy` are registered outputs.

## Structure
- `security_pkg` holds:
  - `DNA_WIDTH_DEFAULT`;
  - the `dna_rd_state_e` enum (IDLE, LOAD, SHIFT, COMPARE, DONE, ERROR);
  - the pass-index type, shared with `key_vault`.
- One sub-module, `dna_clk_div`:
  - inputs: enable and `CLK_DIV`;
  - outputs: the `dna_clk` level, plus `rise_next` and `fall` single-cycle strobes used for sampling and pin updates.
- Bit counter width is $clog2(DNA_WIDTH+1).

## Test plan
- **Clean read.** Stub DNA = 57'h1A2B3C4D5E6F701 on both passes; reset released, CLK_DIV=4. Required: `dna_valid`=1 at cycle 930, `dna_value` matches, `retry_count`=0.
- **Transient mismatch.** Pass 2 of pair 1 has bit 0 flipped, pair 2 is clean. Required: `retry_count`=1, `dna_valid` at 930+929 cycles, correct value.
- **Stuck DOUT.**
  - `dna_dout` tied 0 with MAX_RETRY=3: four pairs run, then `dna_error`=1, `dna_valid`=0, `retry_count`=3, `busy`=0.
  - Repeat with `dna_dout` tied 1: same result.
- **Reset mid-SHIFT.** Assert `rst` at cycle 300. Required: all outputs return to 0 immediately; after release, a full clean read completes at 930 cycles.
- **Start handling.**
  - `start` during SHIFT is ignored, and the original completion time is unchanged.
  - `start` in DONE clears `dna_valid` the next cycle and re-reads.
  - Pin check throughout: exactly one READ-high rising edge and exactly 57 SHIFT-high rising edges per pass.
